// File: rtl/distance_proximity_filter_if.sv
`default_nettype none
// ============================================================================
// Module      : distance_proximity_filter_if
// Description : Distance sample in, filtered average and proximity alarm out.
// Revision    : 1.0 - initial release
// ============================================================================
interface distance_proximity_filter_if #(
  parameter int distance_width = 8
);
  logic [distance_width-1:0] relative_distance;
  logic [distance_width-1:0] filtered;
  logic                      filtered_valid;
  logic                      near;
  logic                      near_rise;
  logic                      near_fall;

  modport master (
    output relative_distance,
    input  filtered, filtered_valid, near, near_rise, near_fall
  );

  modport slave (
    input  relative_distance,
    output filtered, filtered_valid, near, near_rise, near_fall
  );
endinterface
`default_nettype wire

// File: rtl/distance_proximity_filter.sv
`default_nettype none
// ============================================================================
// Module      : distance_proximity_filter
// Description : Periodic 4-sample moving average of a distance reading with a
//               confirmed near/far proximity alarm. Optional build macro:
//               DISTANCE_FILTER_HYSTERESIS_EN (far exit at threshold+hysteresis).
// Revision    : 1.0 - initial release
// ============================================================================
module distance_proximity_filter #(
  parameter int clk_frequency    = 50000000,
  parameter int sample_period_ms = 200,
  parameter int distance_width   = 8,
  parameter int near_threshold   = 40,
  parameter int hysteresis       = 8,
  parameter int confirm_count    = 3
) (
  input  logic clk,
  input  logic rst,
  distance_proximity_filter_if.slave bus
);

  localparam int c_sample_cycles = sample_period_ms * (clk_frequency / 1000);
  localparam int c_timer_w       = (c_sample_cycles > 1) ? $clog2(c_sample_cycles) : 1;
  localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(c_sample_cycles - 1);
  localparam int c_sum_w = distance_width + 2;

`ifdef DISTANCE_FILTER_HYSTERESIS_EN
  localparam int c_hyst = hysteresis;
`else
  localparam int c_hyst = 0 * hysteresis;
`endif
  localparam int c_dist_max = (1 << distance_width) - 1;
  localparam int c_far_raw  = near_threshold + c_hyst;
  localparam logic [distance_width-1:0] c_near_th = distance_width'(near_threshold);
  localparam logic [distance_width-1:0] c_far_th  =
    distance_width'((c_far_raw > c_dist_max) ? c_dist_max : c_far_raw);
  localparam logic [3:0] c_confirm = 4'(confirm_count);

  typedef enum logic [1:0] {
    S_FAR       = 2'd0,
    S_PEND_NEAR = 2'd1,
    S_NEAR      = 2'd2,
    S_PEND_FAR  = 2'd3
  } state_t;

  logic [c_timer_w-1:0]                 r_timer;
  logic [3:0][distance_width-1:0]       r_hist;
  logic [c_sum_w-1:0]                   r_sum;
  logic [2:0]                           r_fill;
  logic [distance_width-1:0]            r_filtered;
  logic                                 r_filtered_valid;
  state_t                               r_state;
  logic [3:0]                           r_cnt;
  logic                                 r_near;
  logic                                 r_near_rise;
  logic                                 r_near_fall;

  logic                                 w_sample;
  logic [c_sum_w-1:0]                   w_sum_next;
  logic                                 w_below;
  logic                                 w_above;

  // r_hist[0] is the newest sample, r_hist[3] the one about to be dropped.
  assign w_sample   = (r_timer == c_timer_last);
  assign w_sum_next = r_sum + c_sum_w'(bus.relative_distance) - c_sum_w'(r_hist[3]);
  assign w_below    = (r_filtered <  c_near_th);
  assign w_above    = (r_filtered >= c_far_th);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer          <= '0;
      r_hist           <= '0;
      r_sum            <= '0;
      r_fill           <= '0;
      r_filtered       <= '0;
      r_filtered_valid <= 1'b0;
    end else begin
      r_filtered_valid <= 1'b0;
      if (w_sample) begin
        r_timer          <= '0;
        r_hist           <= {r_hist[2:0], bus.relative_distance};
        r_sum            <= w_sum_next;
        r_filtered       <= w_sum_next[c_sum_w-1:2];
        r_filtered_valid <= (r_fill >= 3'd3);
        if (r_fill != 3'd4) begin
          r_fill <= r_fill + 3'd1;
        end
      end else begin
        r_timer <= r_timer + c_timer_w'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_FAR;
      r_cnt       <= '0;
      r_near      <= 1'b0;
      r_near_rise <= 1'b0;
      r_near_fall <= 1'b0;
    end else begin
      r_near_rise <= 1'b0;
      r_near_fall <= 1'b0;
      if (r_filtered_valid) begin
        case (r_state)
          S_FAR: begin
            if (w_below) begin
              if (c_confirm == 4'd1) begin
                r_state     <= S_NEAR;
                r_near      <= 1'b1;
                r_near_rise <= 1'b1;
              end else begin
                r_state <= S_PEND_NEAR;
                r_cnt   <= 4'd1;
              end
            end
          end
          S_PEND_NEAR: begin
            if (w_below) begin
              if (r_cnt + 4'd1 == c_confirm) begin
                r_state     <= S_NEAR;
                r_cnt       <= '0;
                r_near      <= 1'b1;
                r_near_rise <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end else begin
              r_state <= S_FAR;
              r_cnt   <= '0;
            end
          end
          S_NEAR: begin
            if (w_above) begin
              if (c_confirm == 4'd1) begin
                r_state     <= S_FAR;
                r_near      <= 1'b0;
                r_near_fall <= 1'b1;
              end else begin
                r_state <= S_PEND_FAR;
                r_cnt   <= 4'd1;
              end
            end
          end
          S_PEND_FAR: begin
            if (w_above) begin
              if (r_cnt + 4'd1 == c_confirm) begin
                r_state     <= S_FAR;
                r_cnt       <= '0;
                r_near      <= 1'b0;
                r_near_fall <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end else begin
              r_state <= S_NEAR;
              r_cnt   <= '0;
            end
          end
          default: r_state <= S_FAR;
        endcase
      end
    end
  end

  assign bus.filtered       = r_filtered;
  assign bus.filtered_valid = r_filtered_valid;
  assign bus.near           = r_near;
  assign bus.near_rise      = r_near_rise;
  assign bus.near_fall      = r_near_fall;

endmodule
`default_nettype wire

// File: tb/tb_distance_proximity_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_distance_proximity_filter
// Description : Directed table-driven bench for distance_proximity_filter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_distance_proximity_filter;

  localparam int W = 8;
`ifdef DISTANCE_FILTER_HYSTERESIS_EN
  localparam bit H = 1'b1;
`else
  localparam bit H = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  distance_proximity_filter_if #(.distance_width(W)) bus ();

  distance_proximity_filter #(
    .clk_frequency   (1000000),
    .sample_period_ms(1),
    .distance_width  (W),
    .near_threshold  (40),
    .hysteresis      (8),
    .confirm_count   (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] din;
    bit         v;
    logic [7:0] f;
    bit         n;
    bit         r;
    bit         fa;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;
  int   split;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void add(logic [7:0] d, bit v, logic [7:0] f, bit n, bit r, bit fa);
    vec_t t;
    t.din = d; t.v = v; t.f = f; t.n = n; t.r = r; t.fa = fa;
    vecs.push_back(t);
  endfunction

  // Entered 1 cycle after a sampling edge; leaves 1 cycle after the next one.
  task automatic run_vec(input int i);
    bus.relative_distance = vecs[i].din;
    tick(998);
    check($sformatf("v%0d early_valid", i), 32'(bus.filtered_valid), 32'd0);
    tick(1);
    check($sformatf("v%0d valid", i), 32'(bus.filtered_valid), 32'(vecs[i].v));
    check($sformatf("v%0d filtered", i), 32'(bus.filtered), 32'(vecs[i].f));
    tick(1);
    check($sformatf("v%0d valid_pulse", i), 32'(bus.filtered_valid), 32'd0);
    check($sformatf("v%0d near", i), 32'(bus.near), 32'(vecs[i].n));
    check($sformatf("v%0d near_rise", i), 32'(bus.near_rise), 32'(vecs[i].r));
    check($sformatf("v%0d near_fall", i), 32'(bus.near_fall), 32'(vecs[i].fa));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " filtered"}, 32'(bus.filtered), 32'd0);
    check({tag, " valid"}, 32'(bus.filtered_valid), 32'd0);
    check({tag, " near"}, 32'(bus.near), 32'd0);
    check({tag, " near_rise"}, 32'(bus.near_rise), 32'd0);
    check({tag, " near_fall"}, 32'(bus.near_fall), 32'd0);
  endtask

  initial begin
    bus.relative_distance = 8'd100;

    // Constant 100 after reset: running sums 100,200,300,400,400
    add(100, 0, 25, 0, 0, 0);
    add(100, 0, 50, 0, 0, 0);
    add(100, 0, 75, 0, 0, 0);
    add(100, 1, 100, 0, 0, 0);
    add(100, 1, 100, 0, 0, 0);
    // 10,20,30,41 then 255; 25 enters PEND_NEAR, 86 aborts to FAR
    add(10, 1, 77, 0, 0, 0);
    add(20, 1, 57, 0, 0, 0);
    add(30, 1, 40, 0, 0, 0);
    add(41, 1, 25, 0, 0, 0);
    add(255, 1, 86, 0, 0, 0);
    // Steady 20: near on the third average below 40
    add(20, 1, 86, 0, 0, 0);
    add(20, 1, 84, 0, 0, 0);
    add(20, 1, 78, 0, 0, 0);
    add(20, 1, 20, 0, 0, 0);
    add(20, 1, 20, 0, 0, 0);
    add(20, 1, 20, 1, 1, 0);
    // Averages reaching 44: held with hysteresis, released without
    add(44, 1, 26, 1, 0, 0);
    add(44, 1, 32, 1, 0, 0);
    add(44, 1, 38, 1, 0, 0);
    add(44, 1, 44, 1, 0, 0);
    add(44, 1, 44, 1, 0, 0);
    add(44, 1, 44, H, 0, !H);
    // Averages 45,47,48,50,50: 48 is the first at/above far_th=48
    add(50, 1, 45, H, 0, 0);
    add(50, 1, 47, H, 0, 0);
    add(50, 1, 48, H, 0, 0);
    add(50, 1, 50, H, 0, 0);
    add(50, 1, 50, 0, 0, H);
    // Two pending-near averages then 65 aborts; zeros then confirm near
    add(20, 1, 42, 0, 0, 0);
    add(20, 1, 35, 0, 0, 0);
    add(20, 1, 27, 0, 0, 0);
    add(200, 1, 65, 0, 0, 0);
    add(0, 1, 60, 0, 0, 0);
    add(0, 1, 55, 0, 0, 0);
    add(0, 1, 50, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 1, 0);
    add(30, 1, 7, 1, 0, 0);
    add(30, 1, 15, 1, 0, 0);
    split = vecs.size();
    // After a mid-run reset the history restarts from empty
    add(100, 0, 25, 0, 0, 0);
    add(100, 0, 50, 0, 0, 0);
    add(100, 0, 75, 0, 0, 0);
    add(100, 1, 100, 0, 0, 0);

    tick(3);
    check_all_zero("in_reset");
    @(posedge clk);
    #1 rst = 1'b1;
    tick(1);
    for (int i = 0; i < split; i++) run_vec(i);

    check("near_before_reset", 32'(bus.near), 32'd1);
    #3 rst = 1'b0;
    #1 check_all_zero("async_reset");
    tick(5);
    check_all_zero("held_reset");
    rst = 1'b1;
    tick(1);
    for (int i = split; i < vecs.size(); i++) run_vec(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
